// File: rtl/dive_pkg.sv
// rtl/dive_pkg.sv - shared encodings and FSM state type for the dive solver
//
// Holds the command encodings carried on in_cmd and the control FSM state
// enum used by dive_solver_aim.
package dive_pkg;

  localparam logic [1:0] CMD_FORWARD = 2'b00;
  localparam logic [1:0] CMD_UP      = 2'b01;
  localparam logic [1:0] CMD_DOWN    = 2'b10;
  localparam logic [1:0] CMD_FINISH  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    AIM_MUL = 2'd1,
    FIN_MUL = 2'd2,
    RESULT  = 2'd3
  } dive_state_t;

endpackage

// File: rtl/dive_seq_mult.sv
// rtl/dive_seq_mult.sv - unsigned shift-add multiplier, one bit per cycle
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : load a and b (ignored while busy)
//   a, b       : WIDTH-bit unsigned operands
//   busy       : high for the WIDTH cycles following start
//   done       : one-cycle pulse on the last busy cycle, product valid
//   product    : 2*WIDTH-bit unsigned result
// Bit 0 of b is consumed on the load edge, bits 1..WIDTH-1 on the following
// edges, so done lands exactly WIDTH cycles after the start edge.
module dive_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (start && !busy) begin
      acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier <= b >> 1;
      count  <= CW'(1);
      busy   <= 1'b1;
    end else if (busy) begin
      if (count == CW'(WIDTH)) begin
        busy <= 1'b0;
      end else begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CW'(1);
      end
    end
  end

  assign done    = busy && (count == CW'(WIDTH));
  assign product = acc;

endmodule

// File: rtl/dive_solver_aim.sv
// rtl/dive_solver_aim.sv - submarine-dive course solver with optional aim mode
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : command stream handshake
//   in_cmd, in_value      : command (forward/up/down/finish) and operand
//   out_valid/out_ready   : result stream handshake
//   out_product           : horizontal * depth, 2*WIDTH unsigned
//   overflow              : sticky wrap flag
// Parameters: WIDTH (register width), MODE (0 = depth by up/down, 1 = aim).
// Build option: define DIVE_OVERFLOW_DETECT_EN to build wrap detection;
// otherwise overflow is tied low.
module dive_solver_aim
  import dive_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MODE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_cmd,
  input  logic [WIDTH-1:0]     in_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 overflow
);

  dive_state_t state, state_nxt;

  logic [WIDTH-1:0]   horiz, depth, aim;
  logic               xfer;
  logic               mult_start, mult_busy, mult_done;
  logic [WIDTH-1:0]   mult_a, mult_b;
  logic [2*WIDTH-1:0] mult_product;

  assign xfer = in_valid && in_ready;

  dive_seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (mult_start),
    .a       (mult_a),
    .b       (mult_b),
    .busy    (mult_busy),
    .done    (mult_done),
    .product (mult_product)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (xfer && in_cmd == CMD_FINISH)                    state_nxt = FIN_MUL;
        else if (xfer && in_cmd == CMD_FORWARD && MODE == 1) state_nxt = AIM_MUL;
      end
      AIM_MUL: if (mult_done) state_nxt = IDLE;
      FIN_MUL: if (mult_done) state_nxt = RESULT;
      RESULT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE) && !mult_busy;
    out_valid  = (state == RESULT);
    mult_start = 1'b0;
    mult_a     = '0;
    mult_b     = '0;
    if (xfer) begin
      if (in_cmd == CMD_FINISH) begin
        mult_start = 1'b1;
        mult_a     = horiz;
        mult_b     = depth;
      end else if (in_cmd == CMD_FORWARD && MODE == 1) begin
        mult_start = 1'b1;
        mult_a     = aim;
        mult_b     = in_value;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      horiz       <= '0;
      depth       <= '0;
      aim         <= '0;
      out_product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            case (in_cmd)
              CMD_FORWARD: horiz <= horiz + in_value;
              CMD_UP: begin
                if (MODE == 1) aim   <= aim - in_value;
                else           depth <= depth - in_value;
              end
              CMD_DOWN: begin
                if (MODE == 1) aim   <= aim + in_value;
                else           depth <= depth + in_value;
              end
              default: ;
            endcase
          end
        end
        AIM_MUL: if (mult_done) depth <= depth + mult_product[WIDTH-1:0];
        FIN_MUL: if (mult_done) out_product <= mult_product;
        RESULT: begin
          if (out_ready) begin
            horiz <= '0;
            depth <= '0;
            aim   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIVE_OVERFLOW_DETECT_EN
  logic ovf_q, ovf_evt;
  logic [WIDTH-1:0] aim_low_sum;

  assign aim_low_sum = depth + mult_product[WIDTH-1:0];

  // A modulo sum smaller than an addend means a carry out; a subtrahend
  // larger than the minuend means a borrow.
  always_comb begin
    ovf_evt = 1'b0;
    if (state == IDLE && xfer) begin
      case (in_cmd)
        CMD_FORWARD: ovf_evt = WIDTH'(horiz + in_value) < horiz;
        CMD_UP:      ovf_evt = (MODE == 1) ? (aim < in_value) : (depth < in_value);
        CMD_DOWN:    ovf_evt = (MODE == 1) ? (WIDTH'(aim + in_value) < aim)
                                           : (WIDTH'(depth + in_value) < depth);
        default:     ovf_evt = 1'b0;
      endcase
    end else if (state == AIM_MUL && mult_done) begin
      ovf_evt = (|mult_product[2*WIDTH-1:WIDTH]) || (aim_low_sum < depth);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                           ovf_q <= 1'b0;
    else if (state == RESULT && out_ready) ovf_q <= 1'b0;
    else if (ovf_evt)                    ovf_q <= 1'b1;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_dive_solver_aim.sv
// tb/tb_dive_solver_aim.sv - scoreboard bench for dive_solver_aim
module tb_dive_solver_aim;
  import dive_pkg::*;

`ifdef DIVE_OVERFLOW_DETECT_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  // index 0: WIDTH 32 MODE 1, index 1: WIDTH 32 MODE 0, index 2: WIDTH 8 MODE 0
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid [3];
  logic [1:0]  in_cmd   [3];
  logic [31:0] in_value [3];
  logic        out_ready[3];
  logic        in_ready [3];
  logic        out_valid[3];
  logic        overflow [3];
  logic [63:0] p_aim, p_flat;
  logic [15:0] p_narrow;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mh[3], md[3], ma[3];
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  dive_solver_aim #(.WIDTH(32), .MODE(1)) u_aim (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_cmd(in_cmd[0]), .in_value(in_value[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_product(p_aim), .overflow(overflow[0]));

  dive_solver_aim #(.WIDTH(32), .MODE(0)) u_flat (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_cmd(in_cmd[1]), .in_value(in_value[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_product(p_flat), .overflow(overflow[1]));

  dive_solver_aim #(.WIDTH(8), .MODE(0)) u_narrow (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_cmd(in_cmd[2]), .in_value(in_value[2][7:0]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_product(p_narrow), .overflow(overflow[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] prod(input int i);
    case (i)
      0:       return p_aim;
      1:       return p_flat;
      default: return {48'b0, p_narrow};
    endcase
  endfunction

  function automatic logic [31:0] msk(input int i);
    return (i == 2) ? 32'hFF : 32'hFFFF_FFFF;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int k = 0; k < 3; k++) begin
      mh[k] = '0; md[k] = '0; ma[k] = '0;
    end
  endtask

  // Reference model update for one accepted command.
  task automatic model(input int i, input logic [1:0] c, input logic [31:0] v_in);
    logic [31:0] v;
    logic [63:0] t;
    v = v_in & msk(i);
    case (c)
      CMD_FORWARD: begin
        mh[i] = (mh[i] + v) & msk(i);
        if (i == 0) begin
          t = 64'(ma[i]) * 64'(v);
          md[i] = (md[i] + t[31:0]) & msk(i);
        end
      end
      CMD_UP: begin
        if (i == 0) ma[i] = (ma[i] - v) & msk(i);
        else        md[i] = (md[i] - v) & msk(i);
      end
      CMD_DOWN: begin
        if (i == 0) ma[i] = (ma[i] + v) & msk(i);
        else        md[i] = (md[i] + v) & msk(i);
      end
      default: begin
        sb.push_back(64'(mh[i]) * 64'(md[i]));
        mh[i] = '0; md[i] = '0; ma[i] = '0;
      end
    endcase
  endtask

  task automatic send(input int i, input logic [1:0] c, input logic [31:0] v);
    int n = 0;
    in_valid[i] = 1'b1;
    in_cmd[i]   = c;
    in_value[i] = v;
    while (!in_ready[i] && n < 200) begin step(); n++; end
    if (n >= 200) check("send_timeout", 64'(n), 64'(0));
    step();
    in_valid[i] = 1'b0;
    model(i, c, v);
  endtask

  task automatic stall(input int i, input int exp);
    int n = 0;
    while (!in_ready[i] && n < 200) begin step(); n++; end
    check("ready_low_cycles", 64'(n), 64'(exp));
  endtask

  task automatic collect(input int i, input bit hold, input logic exp_ovf);
    int n = 0;
    logic [63:0] exp;
    while (!out_valid[i] && n < 200) begin step(); n++; end
    check("result_seen", 64'(out_valid[i]), 64'(1));
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'(0), 64'(1));
      exp = '0;
    end else begin
      exp = sb.pop_front();
    end
    check("product", prod(i), exp);
    check("overflow", 64'(overflow[i]), 64'(exp_ovf));
    if (hold) begin
      for (int k = 0; k < 10; k++) begin
        step();
        check("hold_valid", 64'(out_valid[i]), 64'(1));
        check("hold_product", prod(i), exp);
        check("hold_in_ready", 64'(in_ready[i]), 64'(0));
      end
    end
    out_ready[i] = 1'b1;
    step();
    out_ready[i] = 1'b0;
    check("valid_drop", 64'(out_valid[i]), 64'(0));
    check("ready_back", 64'(in_ready[i]), 64'(1));
    check("overflow_clear", 64'(overflow[i]), 64'(0));
  endtask

  initial begin
    int spurious;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_cmd[k] = 2'b00; in_value[k] = '0; out_ready[k] = 1'b0;
    end
    model_clear();
    step(); step();
    reset = 1'b0;
    step();

    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready", 64'(in_ready[k]), 64'(1));
      check("rst_out_valid", 64'(out_valid[k]), 64'(0));
      check("rst_product", prod(k), 64'(0));
      check("rst_overflow", 64'(overflow[k]), 64'(0));
    end

    // Aim mode reference stream -> 900, 32-cycle stall after each forward
    send(0, CMD_FORWARD, 5); stall(0, 32);
    send(0, CMD_DOWN, 5);
    send(0, CMD_FORWARD, 8); stall(0, 32);
    send(0, CMD_UP, 3);
    send(0, CMD_DOWN, 8);
    send(0, CMD_FORWARD, 2); stall(0, 32);
    send(0, CMD_FINISH, 0);
    check("sb_head_aim", sb[0], 64'd900);
    collect(0, 1'b1, 1'b0);

    // Plain mode, same stream -> 150, never stalls
    send(1, CMD_FORWARD, 5); stall(1, 0);
    send(1, CMD_DOWN, 5);    stall(1, 0);
    send(1, CMD_FORWARD, 8); stall(1, 0);
    send(1, CMD_UP, 3);      stall(1, 0);
    send(1, CMD_DOWN, 8);    stall(1, 0);
    send(1, CMD_FORWARD, 2); stall(1, 0);
    send(1, CMD_FINISH, 0);
    check("sb_head_flat", sb[0], 64'd150);
    collect(1, 1'b0, 1'b0);

    // Fresh streams after the result handshake
    send(0, CMD_FORWARD, 3); stall(0, 32);
    send(0, CMD_DOWN, 4);
    send(0, CMD_FINISH, 0);
    collect(0, 1'b0, 1'b0);
    send(1, CMD_FORWARD, 3);
    send(1, CMD_DOWN, 4);
    send(1, CMD_FINISH, 0);
    check("sb_head_fresh", sb[0], 64'd12);
    collect(1, 1'b0, 1'b0);

    // Reset in the middle of an aim multiply abandons it
    send(0, CMD_DOWN, 4);
    send(0, CMD_FORWARD, 7);
    repeat (5) step();
    check("mid_mul_busy", 64'(in_ready[0]), 64'(0));
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_clear();
    check("post_rst_in_ready", 64'(in_ready[0]), 64'(1));
    check("post_rst_out_valid", 64'(out_valid[0]), 64'(0));
    check("post_rst_product", prod(0), 64'(0));
    spurious = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (out_valid[0] || !in_ready[0]) spurious++;
    end
    check("post_rst_quiet", 64'(spurious), 64'(0));
    send(0, CMD_FINISH, 0);
    collect(0, 1'b0, 1'b0);
    send(0, CMD_DOWN, 2);
    send(0, CMD_FORWARD, 3); stall(0, 32);
    send(0, CMD_FINISH, 0);
    check("sb_head_clean", sb[0], 64'd18);
    collect(0, 1'b0, 1'b0);

    // Narrow width wrap: 200 + 100 mod 256 = 44
    send(2, CMD_DOWN, 200);
    send(2, CMD_DOWN, 100);
    send(2, CMD_FORWARD, 1);
    send(2, CMD_FINISH, 0);
    check("sb_head_narrow", sb[0], 64'd44);
    collect(2, 1'b0, OVF);

    // Back-to-back commands with a borrow below zero
    send(1, CMD_DOWN, 1);
    send(1, CMD_UP, 1);
    send(1, CMD_UP, 1);
    send(1, CMD_FORWARD, 2);
    send(1, CMD_FINISH, 0);
    check("sb_head_borrow", sb[0], 64'h1_FFFF_FFFE);
    collect(1, 1'b0, OVF);

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
